pipeline_interlock_ctrl: RTL and testbench
==========================================

// Module: pipeline_interlock_ctrl
// PURPOSE
// Consumer side of the forwarding/hazard path in the 6-stage 16-bit RISC pipeline (IF,ID,RR,EX,MEM,WB).
// Takes the load-use stall request, the EX-stage branch/jump redirect and the data-memory ready handshake.
// Drives the PC and pipeline-register write enables, bubble inserts and flushes.
// Keeps saturating stall/flush performance counters and a sticky memory-timeout flag.
// PARAMETERS
// PC_W        16   program counter / redirect target width
// CNT_W       16   width of perf counters
// WAIT_LIMIT  64   MEM_WAIT cycles before dmem_timeout_err sets (>=2)
// PORTS
// clk              in   1      single clock, rising edge
// rst_n            in   1      asynchronous, active-low reset
// stall_for_load   in   1      load-use request from forwarding control; may stay high, level not trusted
// branch_taken_ex  in   1      EX resolved a taken branch/jump this cycle
// redirect_pc_ex   in   PC_W   target for branch_taken_ex
// mem_access_mem   in   1      instruction in MEM is LW/SW/LM/SM
// dmem_ready       in   1      data memory completes access this cycle
// pc_wr_en         out  1      PC update enable
// if_id_wr_en, id_rr_wr_en, rr_ex_wr_en, ex_mem_wr_en, mem_wb_wr_en  out 1 each  pipeline-register enables
// bubble_ex_mem    out  1      load NOP (valid=0) into EX/MEM instead of EX result
// bubble_mem_wb    out  1      load NOP into MEM/WB
// flush_if_id, flush_id_rr, flush_rr_ex  out 1 each  squash younger instructions
// pc_redirect_sel  out  1      PC mux selects pc_redirect
// pc_redirect      out  PC_W   = redirect_pc_ex when pc_redirect_sel, else 0
// stall_cycles     out  CNT_W  saturating count of cycles with pc_wr_en=0
// flush_count      out  CNT_W  saturating count of redirects taken
// dmem_timeout_err out  1      sticky; cleared only by reset
// BEHAVIOUR
// - Reset: while rst_n=0 every output 0 (all enables 0, no bubble/flush); state=RUN; counters, wait_cnt, err = 0.
// - FSM states RUN, LD_BUBBLE, MEM_WAIT; next state registered; control outputs combinational from state+inputs.
// - RUN priority: memory wait > load stall > redirect > normal.
//   * mem_access_mem & !dmem_ready: PC and IF/ID..EX/MEM enables 0; mem_wb_wr_en=1, bubble_mem_wb=1; -> MEM_WAIT.
//   * stall_for_load: pc, if_id, id_rr, rr_ex enables 0; ex_mem_wr_en=1, bubble_ex_mem=1; mem_wb_wr_en=1; -> LD_BUBBLE.
//     Branch_taken_ex ignored this cycle (EX operand not valid); re-evaluated next cycle.
//   * branch_taken_ex: all enables 1; pc_redirect_sel=1; flush_if_id/id_rr/rr_ex=1; flush_count+1; stay RUN.
//   * else: all enables 1, no bubble/flush.
// - LD_BUBBLE (exactly 1 cycle): stall_for_load masked (exactly one bubble per hazard even if input sticks);
//   mem-wait and redirect evaluated as in RUN; -> MEM_WAIT if memory wait, else RUN.
//   A continuously high stall_for_load thus yields stall, run, stall, run...
// - MEM_WAIT: enables as on entry; wait_cnt increments (saturating).
//   dmem_ready=1: release cycle with all enables 1, no bubble; redirect evaluated normally; wait_cnt=0; -> RUN.
//   wait_cnt reaching WAIT_LIMIT-1 with dmem_ready=0 sets dmem_timeout_err next edge; waiting continues.
// - Counters: stall_cycles +1 each non-reset cycle with pc_wr_en=0; both counters hold at 2^CNT_W-1, never wrap.
// - Reset asserted mid-stall/wait: state and counters cleared immediately (async); outputs 0 until release.
// - First cycle after rst_n rises is plain RUN.
// STRUCTURE
// - Shared package riscp_pkg:
//   * opcode constants (LOAD=4'b0100, etc.)
//   * interlock state typedef {RUN, LD_BUBBLE, MEM_WAIT} (2-bit)
//   * PC_W/CNT_W defaults.
// - One sub-module, sat_counter #(W): clk, rst_n, inc, count.
//   Instantiated for stall_cycles, flush_count and wait_cnt.
// - FSM and output decode stay in this module.
// TESTING
// 1 Reset: hold rst_n=0 with all inputs 1 -> every output 0; release -> RUN, all enables 1 next cycle.
// 2 stall_for_load held high 4 cycles -> bubble_ex_mem pattern 1,0,1,0; pc_wr_en 0,1,0,1; stall_cycles=2.
// 3 stall_for_load=1 and branch_taken_ex=1 same RUN cycle -> bubble only, pc_redirect_sel=0.
//   Branch held next cycle -> redirect, flush_count=1.
// 4 branch_taken_ex=1, redirect_pc_ex=16'h0040 -> pc_redirect=16'h0040, three flushes=1 for one cycle.
// 5 mem_access_mem=1, dmem_ready low 5 cycles then high -> pc_wr_en 0 x5, bubble_mem_wb 1 x5.
//   Release cycle all enables 1; stall_cycles=5.
// 6 WAIT_LIMIT=4, dmem_ready low 6 cycles -> dmem_timeout_err=1 after 4th wait cycle, stays 1 until rst_n=0.
//   Saturation: force CNT_W=4, 20 stall cycles -> stall_cycles=15.

Source files
------------

// File: rtl/riscp_pkg.sv
// Shared definitions for the 16-bit RISC pipeline: opcodes, interlock states and default widths.
package riscp_pkg;

  localparam int PC_W_DEF       = 16;
  localparam int CNT_W_DEF      = 16;
  localparam int WAIT_LIMIT_DEF = 64;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADI  = 4'b0001;
  localparam logic [3:0] OP_NDU  = 4'b0010;
  localparam logic [3:0] OP_LHI  = 4'b0011;
  localparam logic [3:0] OP_LOAD = 4'b0100;
  localparam logic [3:0] OP_STOR = 4'b0101;
  localparam logic [3:0] OP_LM   = 4'b0110;
  localparam logic [3:0] OP_SM   = 4'b0111;
  localparam logic [3:0] OP_JAL  = 4'b1000;
  localparam logic [3:0] OP_JLR  = 4'b1001;
  localparam logic [3:0] OP_BEQ  = 4'b1100;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LD_BUBBLE = 2'd1,
    ST_MEM_WAIT  = 2'd2
  } ilk_state_e;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_STOR) || (op == OP_LM) || (op == OP_SM);
  endfunction

endpackage

// File: rtl/pipeline_interlock_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_interlock_ctrl.sv
// Pipeline interlock: turns load-use, redirect and dmem-ready events into stage enables,
// bubbles and flushes, with perf counters and a sticky memory-timeout flag.
//
// state        | meaning
// RUN          | normal issue; all hazard sources evaluated
// LD_BUBBLE    | one bubble just inserted for a load-use hazard; stall request masked
// MEM_WAIT     | data memory busy; front of pipe frozen until dmem_ready
module pipeline_interlock_ctrl
  import riscp_pkg::*;
#(
  parameter int PC_W       = PC_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_for_load,
  input  logic             branch_taken_ex,
  input  logic [PC_W-1:0]  redirect_pc_ex,
  input  logic             mem_access_mem,
  input  logic             dmem_ready,
  output logic             pc_wr_en,
  output logic             if_id_wr_en,
  output logic             id_rr_wr_en,
  output logic             rr_ex_wr_en,
  output logic             ex_mem_wr_en,
  output logic             mem_wb_wr_en,
  output logic             bubble_ex_mem,
  output logic             bubble_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_rr,
  output logic             flush_rr_ex,
  output logic             pc_redirect_sel,
  output logic [PC_W-1:0]  pc_redirect,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             dmem_timeout_err
);

  localparam int WC_W = $clog2(WAIT_LIMIT) + 1;

  ilk_state_e      state_q, state_d;
  logic            mem_stall, load_stall, redirect;
  logic            err_q, err_d;
  logic [WC_W-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    pc_wr_en        = 1'b0;
    if_id_wr_en     = 1'b0;
    id_rr_wr_en     = 1'b0;
    rr_ex_wr_en     = 1'b0;
    ex_mem_wr_en    = 1'b0;
    mem_wb_wr_en    = 1'b0;
    bubble_ex_mem   = 1'b0;
    bubble_mem_wb   = 1'b0;
    flush_if_id     = 1'b0;
    flush_id_rr     = 1'b0;
    flush_rr_ex     = 1'b0;
    pc_redirect_sel = 1'b0;
    mem_stall       = 1'b0;
    load_stall      = 1'b0;
    redirect        = 1'b0;
    state_d         = ST_RUN;
    if (rst_n) begin
      // In MEM_WAIT the MEM instruction is frozen, so only dmem_ready matters.
      mem_stall  = (state_q == ST_MEM_WAIT) ? !dmem_ready : (mem_access_mem && !dmem_ready);
      load_stall = (state_q == ST_RUN) && !mem_stall && stall_for_load;
      redirect   = !mem_stall && !load_stall && branch_taken_ex;
      if (mem_stall) begin
        mem_wb_wr_en  = 1'b1;
        bubble_mem_wb = 1'b1;
        state_d       = ST_MEM_WAIT;
      end else if (load_stall) begin
        ex_mem_wr_en  = 1'b1;
        bubble_ex_mem = 1'b1;
        mem_wb_wr_en  = 1'b1;
        state_d       = ST_LD_BUBBLE;
      end else begin
        pc_wr_en        = 1'b1;
        if_id_wr_en     = 1'b1;
        id_rr_wr_en     = 1'b1;
        rr_ex_wr_en     = 1'b1;
        ex_mem_wr_en    = 1'b1;
        mem_wb_wr_en    = 1'b1;
        pc_redirect_sel = redirect;
        flush_if_id     = redirect;
        flush_id_rr     = redirect;
        flush_rr_ex     = redirect;
      end
    end
  end

  assign err_d = err_q | (mem_stall && (wait_cnt == WC_W'(WAIT_LIMIT - 1)));

  assign pc_redirect      = pc_redirect_sel ? redirect_pc_ex : '0;
  assign dmem_timeout_err = err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rst_n && !pc_wr_en),
    .clr   (1'b0),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pc_redirect_sel),
    .clr   (1'b0),
    .count (flush_count)
  );

  sat_counter #(.W(WC_W)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (mem_stall),
    .clr   (!mem_stall),
    .count (wait_cnt)
  );

endmodule

// File: tb/tb_pipeline_interlock_ctrl.sv
// Directed bench for pipeline_interlock_ctrl with a cycle-level behavioural model and literal checks.
module tb_pipeline_interlock_ctrl;

  localparam int PC_W  = 16;
  localparam int CNT_W = 4;
  localparam int WLIM  = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic stall_for_load = 1'b0, branch_taken_ex = 1'b0, mem_access_mem = 1'b0, dmem_ready = 1'b0;
  logic [PC_W-1:0] redirect_pc_ex = '0;
  logic pc_wr_en, if_id_wr_en, id_rr_wr_en, rr_ex_wr_en, ex_mem_wr_en, mem_wb_wr_en;
  logic bubble_ex_mem, bubble_mem_wb, flush_if_id, flush_id_rr, flush_rr_ex, pc_redirect_sel;
  logic [PC_W-1:0] pc_redirect;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic dmem_timeout_err;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  pipeline_interlock_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .WAIT_LIMIT(WLIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .stall_for_load(stall_for_load), .branch_taken_ex(branch_taken_ex),
    .redirect_pc_ex(redirect_pc_ex), .mem_access_mem(mem_access_mem), .dmem_ready(dmem_ready),
    .pc_wr_en(pc_wr_en), .if_id_wr_en(if_id_wr_en), .id_rr_wr_en(id_rr_wr_en),
    .rr_ex_wr_en(rr_ex_wr_en), .ex_mem_wr_en(ex_mem_wr_en), .mem_wb_wr_en(mem_wb_wr_en),
    .bubble_ex_mem(bubble_ex_mem), .bubble_mem_wb(bubble_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_rr(flush_id_rr), .flush_rr_ex(flush_rr_ex),
    .pc_redirect_sel(pc_redirect_sel), .pc_redirect(pc_redirect),
    .stall_cycles(stall_cycles), .flush_count(flush_count), .dmem_timeout_err(dmem_timeout_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Model: what happened last cycle (a bubble was issued / memory was stalling) plus counts.
  bit m_prev_load = 0, m_in_wait = 0, m_err = 0;
  int m_wait_run = 0, m_stalls = 0, m_flushes = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      logic [11:0] exp_v, act_v;
      logic [PC_W-1:0] exp_pc;
      bit ms, ld, rd;
      act_v = {pc_wr_en, if_id_wr_en, id_rr_wr_en, rr_ex_wr_en, ex_mem_wr_en, mem_wb_wr_en,
               bubble_ex_mem, bubble_mem_wb, flush_if_id, flush_id_rr, flush_rr_ex, pc_redirect_sel};
      if (!rst_n) begin
        chk("mon_reset_ctrl", {20'd0, act_v}, 32'd0);
        chk("mon_reset_cnt", {stall_cycles, flush_count, dmem_timeout_err, pc_redirect}, 32'd0);
        m_prev_load = 0; m_in_wait = 0; m_err = 0; m_wait_run = 0; m_stalls = 0; m_flushes = 0;
      end else begin
        ms = m_in_wait ? !dmem_ready : (mem_access_mem && !dmem_ready);
        ld = !m_in_wait && !m_prev_load && !ms && stall_for_load;
        rd = !ms && !ld && branch_taken_ex;
        if (ms)      exp_v = 12'b000001_01_000_0;
        else if (ld) exp_v = 12'b000011_10_000_0;
        else         exp_v = {6'b111111, 2'b00, {3{rd}}, rd};
        exp_pc = rd ? redirect_pc_ex : '0;
        chk("mon_ctrl", {20'd0, act_v}, {20'd0, exp_v});
        chk("mon_pc_redirect", {16'd0, pc_redirect}, {16'd0, exp_pc});
        chk("mon_stall_cycles", 32'(stall_cycles), 32'(m_stalls));
        chk("mon_flush_count", 32'(flush_count), 32'(m_flushes));
        chk("mon_timeout_err", 32'(dmem_timeout_err), 32'(m_err));
        if (!exp_v[11] && m_stalls < CMAX) m_stalls++;
        if (rd && m_flushes < CMAX) m_flushes++;
        m_wait_run = ms ? m_wait_run + 1 : 0;
        if (m_wait_run >= WLIM) m_err = 1;
        m_in_wait = ms;
        m_prev_load = ld;
      end
    end
  end

  // Drive one cycle's inputs just after the rising edge; return after the following falling edge.
  task automatic step(input bit st, input bit br, input logic [PC_W-1:0] tgt, input bit ma, input bit rdy);
    @(posedge clk);
    #1;
    stall_for_load = st; branch_taken_ex = br; redirect_pc_ex = tgt;
    mem_access_mem = ma; dmem_ready = rdy;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, '0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall_for_load = 0; branch_taken_ex = 0; redirect_pc_ex = '0; mem_access_mem = 0; dmem_ready = 0;
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [5:0] pat_a, pat_b;
    int zeros, ones;

    // Reset with every input high
    #2;
    rst_n = 1'b0;
    stall_for_load = 1; branch_taken_ex = 1; redirect_pc_ex = 16'hFFFF; mem_access_mem = 1; dmem_ready = 1;
    mon_en = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    chk("rst_pc_wr_en", 32'(pc_wr_en), 32'd0);
    chk("rst_mem_wb_wr_en", 32'(mem_wb_wr_en), 32'd0);
    chk("rst_redirect", {15'd0, pc_redirect_sel, pc_redirect}, 32'd0);
    stall_for_load = 0; branch_taken_ex = 0; redirect_pc_ex = '0; mem_access_mem = 0; dmem_ready = 0;
    rst_n = 1'b1;
    idle();
    chk("post_rst_enables", {26'd0, pc_wr_en, if_id_wr_en, id_rr_wr_en, rr_ex_wr_en, ex_mem_wr_en, mem_wb_wr_en}, 32'h3F);

    // Sticky load-use request gives alternating bubbles
    do_reset();
    pat_a = '0; pat_b = '0;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, '0, 0, 0);
      pat_a = {pat_a[4:0], bubble_ex_mem};
      pat_b = {pat_b[4:0], pc_wr_en};
    end
    idle();
    chk("ld_bubble_pattern", 32'(pat_a[3:0]), 32'b1010);
    chk("ld_pc_pattern", 32'(pat_b[3:0]), 32'b0101);
    chk("ld_stall_cycles", 32'(stall_cycles), 32'd2);

    // Load stall outranks branch; branch taken on the following cycle
    do_reset();
    step(1, 1, 16'h1234, 0, 0);
    chk("ld_br_bubble", {30'd0, bubble_ex_mem, pc_redirect_sel}, 32'b10);
    step(1, 1, 16'h1234, 0, 0);
    chk("ld_br_redirect", {15'd0, pc_redirect_sel, pc_redirect}, {15'd0, 1'b1, 16'h1234});
    idle();
    chk("ld_br_flush_count", 32'(flush_count), 32'd1);

    // Plain redirect
    do_reset();
    step(0, 1, 16'h0040, 0, 0);
    chk("br_pc_redirect", 32'(pc_redirect), 32'h0040);
    chk("br_flushes", {29'd0, flush_if_id, flush_id_rr, flush_rr_ex}, 32'b111);
    idle();
    chk("br_flush_clear", {29'd0, flush_if_id, flush_id_rr, flush_rr_ex}, 32'd0);

    // Memory wait of 5 cycles then release
    do_reset();
    zeros = 0; ones = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, '0, 1, 0);
      if (!pc_wr_en) zeros++;
      if (bubble_mem_wb) ones++;
    end
    chk("mw_pc_zero_cycles", 32'(zeros), 32'd5);
    chk("mw_bubble_cycles", 32'(ones), 32'd5);
    step(0, 0, '0, 1, 1);
    chk("mw_release", {24'd0, pc_wr_en, if_id_wr_en, id_rr_wr_en, rr_ex_wr_en, ex_mem_wr_en, mem_wb_wr_en,
                       bubble_mem_wb, bubble_ex_mem}, 32'hFC);
    idle();
    chk("mw_stall_cycles", 32'(stall_cycles), 32'd5);

    // Timeout after WLIM wait cycles, sticky until reset; reset lands mid-cycle
    do_reset();
    pat_a = '0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, '0, 1, 0);
      pat_a = {pat_a[4:0], dmem_timeout_err};
    end
    chk("to_err_pattern", 32'(pat_a), 32'b000011);
    step(0, 0, '0, 1, 1);
    idle(); idle();
    chk("to_err_sticky", 32'(dmem_timeout_err), 32'd1);
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 1, 0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_clear", {23'd0, dmem_timeout_err, stall_cycles, pc_wr_en, 3'd0}, 32'd0);
    @(negedge clk); #1;
    mem_access_mem = 0;
    rst_n = 1'b1;
    idle();
    chk("async_rst_run", 32'(pc_wr_en), 32'd1);

    // Counter saturation
    do_reset();
    for (int i = 0; i < 20; i++) step(0, 0, '0, 1, 0);
    step(0, 0, '0, 1, 1);
    idle();
    chk("sat_stall_cycles", 32'(stall_cycles), 32'd15);
    do_reset();
    for (int i = 0; i < 17; i++) step(0, 1, 16'(i * 4), 0, 0);
    idle();
    chk("sat_flush_count", 32'(flush_count), 32'd15);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
